// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the RISC-V immediate generator: immediate-source codes
// and the base/RV64 opcode values the decoder recognises.
package imm_pkg;

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_U = 3'b101;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream instruction handshake plus downstream immediate handshake of the
// immediate generator; the slave modport is the generator itself.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  // A beat moves on a side exactly in a cycle where valid and ready are both 1
  // at the rising edge; i_flush drops everything in flight, including that beat.
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [2:0]      o_src_imm;
  logic [XLEN-1:0] o_imm;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_inst, i_flush, i_ready,
    output o_ready, o_valid, o_src_imm, o_imm, o_illegal
  );

  modport master (
    output i_valid, i_inst, i_flush, i_ready,
    input  o_ready, o_valid, o_src_imm, o_imm, o_illegal
  );
endinterface

// File: rtl/imm_gen_pipe_type_dec.sv
// Combinational opcode decoder: maps inst[6:0] to the immediate-source code
// and flags opcodes outside the supported set (RV64-only ones when XLEN=32).
module imm_type_dec
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0] opcode,
  output logic [2:0] src_imm,
  output logic       illegal
);

  always_comb begin
    src_imm = IMM_R;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:                       src_imm = IMM_R;
      OPC_OPIMM, OPC_LOAD, OPC_JALR: src_imm = IMM_I;
      OPC_STORE:                    src_imm = IMM_S;
      OPC_BRANCH:                   src_imm = IMM_B;
      OPC_JAL:                      src_imm = IMM_J;
      OPC_LUI, OPC_AUIPC:           src_imm = IMM_U;
      OPC_OP32:                     illegal = (XLEN != 64);
      OPC_OPIMM32: begin
        if (XLEN == 64) src_imm = IMM_I;
        else            illegal = 1'b1;
      end
      default:                      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: S1 registers the decoded type, S2 registers
// the assembled sign-extended immediate, with valid/ready flow control.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_ZERO = 1'b1
) (
  input logic           i_clk,
  input logic           i_rst,
  imm_gen_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic        s1_valid;
  logic [31:7] s1_inst;
  logic [2:0]  s1_src;
  logic        s1_illegal;

  logic            s2_valid;
  logic [2:0]      s2_src;
  logic [XLEN-1:0] s2_imm;
  logic            s2_illegal;

  logic [2:0]      dec_src;
  logic            dec_illegal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic            s1_adv;
  logic            s2_adv;

  imm_type_dec #(.XLEN(XLEN)) u_type_dec (
    .opcode  (bus.i_inst[6:0]),
    .src_imm (dec_src),
    .illegal (dec_illegal)
  );

  assign s2_adv = !s2_valid || bus.i_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Illegal entries carry src 000, so the override below wins over IMM_R.
  always_comb begin
    imm32 = 32'd0;
    case (s1_src)
      IMM_I:   imm32 = {{20{s1_inst[31]}}, s1_inst[31:20]};
      IMM_S:   imm32 = {{20{s1_inst[31]}}, s1_inst[31:25], s1_inst[11:7]};
      IMM_B:   imm32 = {{19{s1_inst[31]}}, s1_inst[31], s1_inst[7],
                        s1_inst[30:25], s1_inst[11:8], 1'b0};
      IMM_J:   imm32 = {{11{s1_inst[31]}}, s1_inst[31], s1_inst[19:12],
                        s1_inst[20], s1_inst[30:21], 1'b0};
      IMM_U:   imm32 = {s1_inst[31:12], 12'd0};
      default: imm32 = 32'd0;
    endcase
    if (s1_illegal) begin
      imm32 = ILLEGAL_ZERO ? 32'd0 : {{20{s1_inst[31]}}, s1_inst[31:20]};
    end
  end

  if (XLEN == 64) begin : g_rv64
    assign imm_x = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_rv32
    assign imm_x = imm32;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_inst    <= '0;
      s1_src     <= IMM_R;
      s1_illegal <= 1'b0;
      s2_valid   <= 1'b0;
      s2_src     <= IMM_R;
      s2_imm     <= '0;
      s2_illegal <= 1'b0;
    end else if (bus.i_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_src     <= s1_src;
          s2_imm     <= imm_x;
          s2_illegal <= s1_illegal;
        end
      end
      if (s1_adv) begin
        s1_valid <= bus.i_valid;
        if (bus.i_valid) begin
          s1_inst    <= bus.i_inst[31:7];
          s1_src     <= dec_src;
          s1_illegal <= dec_illegal;
        end
      end
    end
  end

  assign bus.o_ready   = s1_adv;
  assign bus.o_valid   = s2_valid;
  assign bus.o_src_imm = s2_src;
  assign bus.o_imm     = s2_imm;
  assign bus.o_illegal = s2_illegal;

endmodule
